scan_decoder: RTL and testbench

Parameterised registered N-to-2^N one-hot decoder, the successor to the combinational 3-to-8 decoder. Two modes:
- Direct: registered decode of a select input.
- Scan: an internal index steps through all outputs, holding each for a programmable dwell time.

Used for digit/row strobing and channel-select fan-out. It sits between control logic and multiplexed output drivers.

---
 rtl/scan_decoder_if.sv | 28 ++
 rtl/scan_decoder.sv | 95 +++++++++
 tb/tb_scan_decoder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/scan_decoder_if.sv
// Signal bundle between control logic and scan_decoder: enable/mode/load/select in,
// one-hot strobe, current index, wrap pulse and FSM state out.
interface scan_decoder_if #(
    parameter int SEL_W = 3
);
    localparam int OUT_W = 2 ** SEL_W;

    // No valid/ready pair here: en and mode are levels sampled every rising edge,
    // load is a single-cycle pulse honoured only while en=1 and mode=1 are presented.
    logic             en;
    logic             mode;
    logic             load;
    logic [SEL_W-1:0] data_in;
    logic [OUT_W-1:0] data_out;
    logic [SEL_W-1:0] index;
    logic             wrap;
    logic [1:0]       state_dbg;

    modport master (
        output en, mode, load, data_in,
        input  data_out, index, wrap, state_dbg
    );

    modport slave (
        input  en, mode, load, data_in,
        output data_out, index, wrap, state_dbg
    );
endinterface

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with direct and dwell-timed scan modes.
// Define SCAN_DECODER_ACTIVE_LOW_EN to invert data_out (active bit 0, idle/reset all ones).
module scan_decoder #(
    parameter int SEL_W   = 3,
    parameter int DWELL   = 4,
    parameter int DWELL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    scan_decoder_if.slave    bus
);
    localparam int OUT_W = 2 ** SEL_W;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]   IDX_MAX    = '1;

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] OFF_MASK = '1;
`else
    localparam logic [OUT_W-1:0] OFF_MASK = '0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t             state, next_state;
    logic [SEL_W-1:0]   index_q, index_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               wrap_q, wrap_d;

    // Polarity is applied here so the output register holds the final pin value.
    function automatic logic [OUT_W-1:0] strobe(input logic [SEL_W-1:0] sel);
        logic [OUT_W-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v ^ OFF_MASK;
    endfunction

    // The decision for each edge is taken from the en/mode presented in that cycle;
    // the registered state only tells a fresh scan entry apart from a running scan.
    always_comb begin
        next_state = IDLE;
        index_d    = index_q;
        dwell_d    = '0;
        wrap_d     = 1'b0;
        out_d      = OFF_MASK;
        if (bus.en) begin
            next_state = bus.mode ? SCAN : DIRECT;
        end
        case (next_state)
            DIRECT: begin
                index_d = bus.data_in;
                out_d   = strobe(bus.data_in);
            end
            SCAN: begin
                if (bus.load) begin
                    index_d = bus.data_in;
                end else if (state == SCAN) begin
                    if (dwell_q == DWELL_LAST) begin
                        index_d = index_q + SEL_W'(1);
                        wrap_d  = (index_q == IDX_MAX);
                    end else begin
                        dwell_d = dwell_q + DWELL_W'(1);
                    end
                end
                out_d = strobe(index_d);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            index_q <= '0;
            dwell_q <= '0;
            out_q   <= OFF_MASK;
            wrap_q  <= 1'b0;
        end else begin
            state   <= next_state;
            index_q <= index_d;
            dwell_q <= dwell_d;
            out_q   <= out_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.data_out  = out_q;
    assign bus.index     = index_q;
    assign bus.wrap      = wrap_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_scan_decoder.sv
// Randomized and directed bench for scan_decoder against a cycle-level behavioural model.
module tb_scan_decoder;
  localparam int SEL_W = 3;
  localparam int DWELL = 4;
  localparam int OUT_W = 2 ** SEL_W;

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] OFF = '1;
`else
  localparam logic [OUT_W-1:0] OFF = '0;
`endif

  logic clk;
  logic rst;

  scan_decoder_if #(.SEL_W(SEL_W)) bus ();

  scan_decoder #(.SEL_W(SEL_W), .DWELL(DWELL), .DWELL_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int               m_idx;
  int               m_dwell;
  bit               m_scan;
  bit               m_wrap;
  logic [OUT_W-1:0] exp_q[$];
  int               n_checks;
  int               n_pass;

  function automatic logic [OUT_W-1:0] pin_value(input int i);
    logic [OUT_W-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v ^ OFF;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_idx = 0;
    m_dwell = 0;
    m_scan = 0;
    m_wrap = 0;
    exp_q.delete();
    exp_q.push_back(OFF);
  endtask

  // one rising edge as seen from the rules: en/mode select the behaviour for this edge
  task automatic model_edge(input bit e, input bit m, input bit l, input int d);
    m_wrap = 0;
    if (!e) begin
      m_dwell = 0;
      m_scan = 0;
      exp_q.push_back(OFF);
    end else if (!m) begin
      m_idx = d;
      m_dwell = 0;
      m_scan = 0;
      exp_q.push_back(pin_value(d));
    end else begin
      if (l) begin
        m_idx = d;
        m_dwell = 0;
      end else if (!m_scan) begin
        m_dwell = 0;
      end else if (m_dwell == DWELL - 1) begin
        m_dwell = 0;
        m_wrap = (m_idx == OUT_W - 1);
        m_idx = (m_idx + 1) % OUT_W;
      end else begin
        m_dwell++;
      end
      m_scan = 1;
      exp_q.push_back(pin_value(m_idx));
    end
  endtask

  task automatic check_outputs();
    logic [OUT_W-1:0] exp;
    while (exp_q.size() > 1) void'(exp_q.pop_front());
    exp = exp_q[0];
    check("data_out", 64'(bus.data_out), 64'(exp));
    check("index", 64'(bus.index), 64'(m_idx));
    check("wrap", 64'(bus.wrap), 64'(m_wrap));
    check("at_most_one_active", 64'($countones(bus.data_out ^ OFF) <= 1), 64'(1));
  endtask

  // driver: present inputs, take one edge, compare just after it
  task automatic step(input bit e, input bit m, input bit l, input int d);
    bus.en = e;
    bus.mode = m;
    bus.load = l;
    bus.data_in = SEL_W'(d);
    @(posedge clk);
    model_edge(e, m, l, d);
    #1;
    check_outputs();
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_data_out", 64'(bus.data_out), 64'(OFF));
    check("rst_index", 64'(bus.index), 64'(0));
    check("rst_wrap", 64'(bus.wrap), 64'(0));
    @(posedge clk);
    #1;
    check_outputs();
    #2 rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    bus.en = 1'b0;
    bus.mode = 1'b0;
    bus.load = 1'b0;
    bus.data_in = '0;
    rst = 1'b1;
    model_reset();
    #1;
    check("reset_data_out", 64'(bus.data_out), 64'(OFF));
    check("reset_index", 64'(bus.index), 64'(0));
    check("reset_wrap", 64'(bus.wrap), 64'(0));
    @(posedge clk);
    #1;
    check_outputs();
    #2 rst = 1'b0;

    // direct decode, each select held two cycles
    for (int d = 0; d < OUT_W; d++) begin
      step(1, 0, 0, d);
      step(1, 0, 0, d);
    end
    step(0, 0, 0, 0);

    // scan from index 0 through more than one full period
    step(1, 0, 0, 0);
    for (int k = 0; k < OUT_W * DWELL + 8; k++) step(1, 1, 0, 0);

    // load landing on the dwell-expiry cycle
    for (int k = 0; k < 16 && m_dwell != DWELL - 1; k++) step(1, 1, 0, 0);
    step(1, 1, 1, 5);
    check("load_index", 64'(bus.index), 64'(5));
    for (int k = 0; k < DWELL + 2; k++) step(1, 1, 0, 0);

    // enable gating at index 3, then resume
    for (int k = 0; k < 64 && m_idx != 3; k++) step(1, 1, 0, 0);
    check("reach_idx3", 64'(bus.index), 64'(3));
    step(1, 1, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0);
    for (int k = 0; k < DWELL * 2 + 1; k++) step(1, 1, 0, 0);

    // scan to direct switch mid-dwell, then back
    step(1, 0, 0, 2);
    step(1, 1, 0, 7);
    for (int k = 0; k < DWELL + 2; k++) step(1, 1, 0, 0);

    // async reset between edges at index 6
    for (int k = 0; k < 64 && m_idx != 6; k++) step(1, 1, 0, 0);
    check("reach_idx6", 64'(bus.index), 64'(6));
    async_reset();
    for (int k = 0; k < DWELL + 2; k++) step(1, 1, 0, 0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0, int'($urandom_range(0, OUT_W - 1)));
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
